// File: rtl/ahb_csr_bridge.sv
// ahb_csr_bridge: AHB-Lite subordinate bridging to the I3C CSR cpuif.
// Optional write strobes: define AHB_CSR_BRIDGE_WSTRB_EN.
module ahb_csr_bridge #(
   parameter int AHB_DATA_WIDTH = 64,
   parameter int AHB_ADDR_WIDTH = 32,
   parameter int CSR_DATA_WIDTH = 32,
   parameter int CSR_ADDR_WIDTH = 12,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                        hclk_i,
   input  logic                        hreset_i,
   input  logic [AHB_ADDR_WIDTH-1:0]   haddr_i,
   input  logic [2:0]                  hsize_i,
   input  logic [1:0]                  htrans_i,
   input  logic                        hwrite_i,
   input  logic                        hsel_i,
   input  logic                        hready_i,
   input  logic [AHB_DATA_WIDTH-1:0]   hwdata_i,
   input  logic [AHB_DATA_WIDTH/8-1:0] hwstrb_i,
   output logic [AHB_DATA_WIDTH-1:0]   hrdata_o,
   output logic                        hreadyout_o,
   output logic                        hresp_o,
   output logic                        s_cpuif_req,
   output logic                        s_cpuif_req_is_wr,
   output logic [CSR_ADDR_WIDTH-1:0]   s_cpuif_addr,
   output logic [CSR_DATA_WIDTH-1:0]   s_cpuif_wr_data,
   output logic [CSR_DATA_WIDTH-1:0]   s_cpuif_wr_biten,
   input  logic                        s_cpuif_req_stall_wr,
   input  logic                        s_cpuif_req_stall_rd,
   input  logic                        s_cpuif_rd_ack,
   input  logic                        s_cpuif_rd_err,
   input  logic [CSR_DATA_WIDTH-1:0]   s_cpuif_rd_data,
   input  logic                        s_cpuif_wr_ack,
   input  logic                        s_cpuif_wr_err
);
   localparam int AHB_B   = AHB_DATA_WIDTH / 8;
   localparam int CSR_B   = CSR_DATA_WIDTH / 8;
   localparam int AHB_LSB = $clog2(AHB_B);
   localparam int CSR_LSB = $clog2(CSR_B);
   localparam int NLANE   = AHB_B / CSR_B;
   localparam int TW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [TW-1:0] TMAX = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   typedef enum logic [2:0] {IDLE, REQ, WAIT, RESP, ERR1, ERR2} state_t;

   state_t                      state_q, state_d;
   logic [CSR_ADDR_WIDTH-1:0]   addr_q;
   logic [2:0]                  size_q;
   logic                        wr_q;
   logic [TW-1:0]               timer_q;
   logic [AHB_DATA_WIDTH-1:0]   hrdata_q;
   logic                        open_st, accept, misalign, illegal;
   logic                        stall, ack, err, done, timeout, in_req;
   logic [AHB_LSB-1:0]          lane;
   logic [CSR_DATA_WIDTH-1:0]   wsel, biten_w;
   logic [CSR_B-1:0]            ssel, bmask, byte_en;
   logic [AHB_DATA_WIDTH-1:0]   rd_lane;
   int                          boff, nbytes;
   logic                        unused_ok;

   assign open_st = (state_q == IDLE) || (state_q == RESP) || (state_q == ERR2);
   assign accept  = open_st && hsel_i && hready_i && htrans_i[1];

   // Flag an address not aligned to the transfer size
   always_comb begin
      misalign = 1'b0;
      for (int i = 0; i < 8; i++)
         if ((i < int'(hsize_i)) && haddr_i[i]) misalign = 1'b1;
   end

   assign illegal = (int'(hsize_i) > CSR_LSB) || misalign;
   assign stall   = wr_q ? s_cpuif_req_stall_wr : s_cpuif_req_stall_rd;
   assign ack     = s_cpuif_rd_ack || s_cpuif_wr_ack;
   assign err     = s_cpuif_rd_err || s_cpuif_wr_err;
   assign done    = ack && (((state_q == REQ) && !stall) || (state_q == WAIT));
   assign timeout = (TIMEOUT_CYCLES != 0) && (timer_q == TMAX);
   assign lane    = addr_q[AHB_LSB-1:0] >> CSR_LSB;

   // Pick the CSR-sized lane of write data/strobes and place read data in its lane
   always_comb begin
      wsel    = '0;
      ssel    = '0;
      rd_lane = '0;
      for (int l = 0; l < NLANE; l++) begin
         if (int'(lane) == l) begin
            wsel = hwdata_i[l*CSR_DATA_WIDTH +: CSR_DATA_WIDTH];
            ssel = hwstrb_i[l*CSR_B +: CSR_B];
            rd_lane[l*CSR_DATA_WIDTH +: CSR_DATA_WIDTH] = s_cpuif_rd_data;
         end
      end
   end

   assign boff   = int'(addr_q[CSR_LSB-1:0]);
   assign nbytes = 1 << size_q;

   // Byte enables covering the addressed bytes, expanded to bit enables
   always_comb begin
      bmask = '0;
      for (int b = 0; b < CSR_B; b++)
         if ((b >= boff) && (b < boff + nbytes)) bmask[b] = 1'b1;
`ifdef AHB_CSR_BRIDGE_WSTRB_EN
      byte_en = bmask & ssel;
`else
      byte_en = bmask;
`endif
      biten_w = '0;
      for (int b = 0; b < CSR_B; b++)
         biten_w[b*8 +: 8] = {8{byte_en[b]}};
   end

   assign unused_ok = ^{haddr_i, htrans_i, ssel};

   assign in_req            = (state_q == REQ);
   assign s_cpuif_req       = in_req;
   assign s_cpuif_req_is_wr = in_req && wr_q;
   assign s_cpuif_addr      = in_req ?
                              {addr_q[CSR_ADDR_WIDTH-1:CSR_LSB], {CSR_LSB{1'b0}}} : '0;
   assign s_cpuif_wr_data   = (in_req && wr_q) ? wsel : '0;
   assign s_cpuif_wr_biten  = (in_req && wr_q) ? biten_w : '0;
   assign hrdata_o          = hrdata_q;

   // Next state and AHB response signalling
   always_comb begin
      state_d     = state_q;
      hreadyout_o = 1'b1;
      hresp_o     = 1'b0;
      unique case (state_q)
         IDLE, RESP, ERR2: begin
            hresp_o = (state_q == ERR2);
            if (accept) state_d = illegal ? ERR1 : REQ;
            else        state_d = IDLE;
         end
         REQ: begin
            hreadyout_o = 1'b0;
            if (done)         state_d = err ? ERR1 : RESP;
            else if (timeout) state_d = ERR1;
            else if (!stall)  state_d = WAIT;
         end
         WAIT: begin
            hreadyout_o = 1'b0;
            if (done)         state_d = err ? ERR1 : RESP;
            else if (timeout) state_d = ERR1;
         end
         ERR1: begin
            hreadyout_o = 1'b0;
            hresp_o     = 1'b1;
            state_d     = ERR2;
         end
         default: state_d = IDLE;
      endcase
   end

   // State, captured address phase, timeout counter and read data
   always_ff @(posedge hclk_i or posedge hreset_i) begin
      if (hreset_i) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         size_q   <= '0;
         wr_q     <= 1'b0;
         timer_q  <= '0;
         hrdata_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            addr_q <= haddr_i[CSR_ADDR_WIDTH-1:0];
            size_q <= hsize_i;
            wr_q   <= hwrite_i;
         end
         if ((state_q == REQ || state_q == WAIT) &&
             (state_d == REQ || state_d == WAIT))
            timer_q <= timer_q + 1'b1;
         else
            timer_q <= '0;
         if (done && s_cpuif_rd_ack) hrdata_q <= rd_lane;
      end
   end
endmodule
